dsp_mac_sequencer: RTL and testbench

//  Controls one DSP48A1 slice used as a multiply-accumulator (P += A*B).
//  - Clears P, then streams len operand pairs through the slice via a valid/ready handshake.
//  - Gates each pipeline-stage clock enable so that only accepted operands advance.
//  - Waits for the pipeline to drain, then holds the 48-bit dot-product result until acknowledged.

---
 rtl/dsp_mac_sequencer.sv | 122 ++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Sequencer for one DSP48A1 slice used as a multiply-accumulator (P += A*B).
// Clears P, streams len operand pairs through a gated pipeline, drains it and holds the result.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned PIPE_LAT   = 3,
  parameter logic [7:0]  OPMODE_ACC = 8'h09
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                abort,
  input  logic                op_valid,
  output logic                op_ready,
  output logic [PIPE_LAT-1:0] dsp_ce,
  output logic                dsp_rstp,
  output logic [7:0]          dsp_opmode,
  input  logic [47:0]         dsp_p,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ack,
  output logic [47:0]         result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [PIPE_LAT-2:0] tok_q, tok_d;
  logic [47:0]         result_q, result_d;
  logic                accept;
  logic [PIPE_LAT-1:0] tok_sh;

  // Stage 0 is enabled by the accept itself; later stages follow the token pipe.
  assign tok_sh = {tok_q, accept};
  assign dsp_ce = tok_sh;
  assign result = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tok_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tok_q    <= tok_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tok_d      = tok_q;
    result_d   = result_q;
    op_ready   = 1'b0;
    dsp_rstp   = 1'b0;
    dsp_opmode = '0;
    busy       = (state_q != S_IDLE);
    res_valid  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = S_CLEAR;
            cnt_d   = len;
          end else begin
            state_d  = S_HOLD;
            result_d = '0;
          end
        end
      end
      S_CLEAR: begin
        dsp_rstp   = 1'b1;
        dsp_opmode = OPMODE_ACC;
        state_d    = S_FEED;
      end
      S_FEED: begin
        op_ready   = 1'b1;
        dsp_opmode = OPMODE_ACC;
        accept     = op_valid;
        if (accept) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        dsp_opmode = OPMODE_ACC;
        if (tok_q == '0) begin
          result_d = dsp_p;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        res_valid = 1'b1;
        if (res_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_FEED || state_q == S_DRAIN) tok_d = tok_sh[PIPE_LAT-2:0];

    // Abort overrides everything decided above, including a same-cycle capture in DRAIN.
    if (abort && (state_q == S_CLEAR || state_q == S_FEED || state_q == S_DRAIN)) begin
      state_d  = S_IDLE;
      tok_d    = '0;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural PIPE_LAT=3 DSP slice, vector table plus corner sequences.
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  dsp_ce;
  logic        dsp_rstp;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        busy;
  logic        res_valid;
  logic        res_ack = 1'b0;
  logic [47:0] result;

  dsp_mac_sequencer #(
    .LEN_W(8),
    .PIPE_LAT(3),
    .OPMODE_ACC(8'h09)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .dsp_ce(dsp_ce), .dsp_rstp(dsp_rstp),
    .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .busy(busy), .res_valid(res_valid),
    .res_ack(res_ack), .result(result)
  );

  always #5 clk = ~clk;

  // Behavioural slice: A/B regs, M reg, P reg with sync clear; accumulates only with opmode 8'h09.
  logic signed [17:0] a_in = '0, b_in = '0, a_q = '0, b_q = '0;
  logic signed [35:0] m_q = '0;
  logic [47:0]        p_q = '0;
  assign dsp_p = p_q;

  always @(posedge clk) begin
    if (dsp_ce[0]) begin
      a_q <= a_in;
      b_q <= b_in;
    end
    if (dsp_ce[1]) m_q <= a_q * b_q;
    if (dsp_rstp) p_q <= '0;
    else if (dsp_ce[2] && dsp_opmode == 8'h09) p_q <= p_q + {{12{m_q[35]}}, m_q};
  end

  int unsigned cyc = 0, last_acc = 0, n_acc = 0, n_rstp = 0;
  int unsigned n_ce0 = 0, n_ce1 = 0, n_ce2 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_valid && op_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= cyc;
    end
    if (dsp_rstp)  n_rstp <= n_rstp + 1;
    if (dsp_ce[0]) n_ce0 <= n_ce0 + 1;
    if (dsp_ce[1]) n_ce1 <= n_ce1 + 1;
    if (dsp_ce[2]) n_ce2 <= n_ce2 + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0]       gap;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [47:0]      exp;
  } vec_t;

  function automatic logic [3:0][17:0] pk(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][17:0] r;
    r[0] = x0[17:0];
    r[1] = x1[17:0];
    r[2] = x2[17:0];
    r[3] = x3[17:0];
    return r;
  endfunction

  function automatic vec_t mkv(input int l, input int g, input logic [3:0][17:0] a,
                               input logic [3:0][17:0] b, input logic [47:0] e);
    vec_t v;
    v.len = l[7:0];
    v.gap = g[3:0];
    v.a   = a;
    v.b   = b;
    v.exp = e;
    return v;
  endfunction

  vec_t vecs [6];

  task automatic run_job(input vec_t v, input bit do_ack);
    int unsigned acc0, rs0, c0, c1, c2, start_cyc, idx, gapc, budget;
    bit ce_bad;
    acc0 = n_acc; rs0 = n_rstp; c0 = n_ce0; c1 = n_ce1; c2 = n_ce2;
    @(negedge clk);
    start = 1'b1;
    len = v.len;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (v.len != 0) chk("clear_state", {dsp_rstp, dsp_opmode, op_ready, busy}, {1'b1, 8'h09, 1'b0, 1'b1});
    else            chk("len0_hold", {res_valid, dsp_rstp, result}, {1'b1, 1'b0, 48'h0});
    idx = 0; gapc = 0; budget = 0; ce_bad = 0;
    while (idx < v.len && budget < 60) begin
      if (gapc > 0) begin
        op_valid = 1'b0;
        gapc--;
      end else begin
        op_valid = 1'b1;
        a_in = v.a[idx];
        b_in = v.b[idx];
      end
      #1;
      if (dsp_ce[0] !== (op_valid & op_ready)) ce_bad = 1;
      if (op_valid && op_ready) begin
        idx++;
        gapc = v.gap;
      end
      @(negedge clk);
      budget++;
    end
    op_valid = 1'b0;
    chk("ce0_eq_accept", ce_bad, 1'b0);
    budget = 0;
    while (!res_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("res_valid_seen", res_valid, 1'b1);
    chk("result", result, v.exp);
    if (v.len != 0) chk("res_latency", cyc - last_acc, 4);
    else            chk("len0_latency", cyc - start_cyc, 1);
    chk("accept_count", n_acc - acc0, v.len);
    chk("ce0_count", n_ce0 - c0, v.len);
    chk("ce1_count", n_ce1 - c1, v.len);
    chk("ce2_count", n_ce2 - c2, v.len);
    chk("rstp_count", n_rstp - rs0, (v.len != 0) ? 1 : 0);
    if (do_ack) begin
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      chk("ack_to_idle", {busy, res_valid, dsp_opmode}, 10'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned accepted, budget;
    logic [47:0] held;
    bit bad;

    vecs[0] = mkv(4, 0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 48'd70);
    vecs[1] = mkv(3, 2, pk(2, 3, 4, 0), pk(2, 3, 4, 0), 48'd29);
    vecs[2] = mkv(0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 48'd0);
    vecs[3] = mkv(3, 1, pk(-100, 200, -5, 0), pk(7, -3, -9, 0), 48'hFFFF_FFFF_FB19);
    vecs[4] = mkv(1, 0, pk(-3, 0, 0, 0), pk(7, 0, 0, 0), 48'hFFFF_FFFF_FFEB);
    vecs[5] = mkv(2, 0, pk(1, 1, 0, 0), pk(1, 1, 0, 0), 48'd2);

    repeat (2) @(negedge clk);
    chk("reset_outputs", {op_ready, dsp_ce, dsp_rstp, dsp_opmode, busy, res_valid, result},
        '0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_job(vecs[i], 1'b1);

    // HOLD stability with start pulsed, then ack and start together
    run_job(vecs[0], 1'b0);
    held = result;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      len = 8'd5;
      @(negedge clk);
      if (result !== held || res_valid !== 1'b1 || busy !== 1'b1 || dsp_rstp !== 1'b0) bad = 1;
    end
    start = 1'b0;
    chk("hold_stable", bad, 1'b0);
    res_ack = 1'b1;
    start = 1'b1;
    len = 8'd2;
    @(negedge clk);
    res_ack = 1'b0;
    start = 1'b0;
    chk("ack_start_idle", {busy, res_valid}, 2'b00);
    @(negedge clk);
    chk("no_new_job", {busy, dsp_rstp, op_ready}, 3'b000);

    // Abort after two accepts of a five-pair job
    @(negedge clk);
    start = 1'b1;
    len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    accepted = 0;
    budget = 0;
    while (accepted < 2 && budget < 20) begin
      op_valid = 1'b1;
      a_in = 18'(accepted + 1);
      b_in = 18'sd1;
      #1;
      if (op_valid && op_ready) accepted++;
      @(negedge clk);
      budget++;
    end
    op_valid = 1'b0;
    chk("abort_two_accepts", accepted, 2);
    abort = 1'b1;
    #1;
    chk("abort_tok_live", dsp_ce[1], 1'b1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, dsp_ce, res_valid, op_ready, dsp_opmode}, 14'h0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    chk("abort_no_result", bad, 1'b0);
    run_job(vecs[4], 1'b1);

    // Asynchronous reset in the middle of DRAIN
    @(negedge clk);
    start = 1'b1;
    len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    accepted = 0;
    budget = 0;
    while (accepted < 2 && budget < 20) begin
      op_valid = 1'b1;
      a_in = 18'sd1;
      b_in = 18'sd1;
      #1;
      if (op_valid && op_ready) accepted++;
      @(negedge clk);
      budget++;
    end
    op_valid = 1'b0;
    chk("drain_entered", {busy, op_ready, res_valid}, 3'b100);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {op_ready, dsp_ce, dsp_rstp, dsp_opmode, busy, res_valid, result}, '0);
    #1 rst = 1'b0;
    run_job(vecs[5], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
